edge_detect_bank: RTL and testbench

EDGE_DETECT_BANK -- requirements
Module: edge_detect_bank

---
 rtl/edge_detect_pkg.sv | 16 +
 rtl/edge_debounce.sv | 48 ++++
 rtl/edge_detect_bank.sv | 86 ++++++++
 tb/tb_edge_detect_bank.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/edge_detect_pkg.sv
// Shared definitions for edge_detect_bank: edge-select encodings and helpers.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } mode_t;

  // Counter wide enough to hold DB_CYCLES without wrapping.
  function automatic int unsigned cnt_width(input int unsigned db_cycles);
    return $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/edge_debounce.sv
// One channel's debounce: a level must persist DB_CYCLES cycles before it is accepted.
// Counter is built only when EDGE_DETECT_DEBOUNCE_EN is defined; otherwise stable follows sync_in.
module edge_debounce
  import edge_detect_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic stable
);

  if (DB_CYCLES < 1) begin : g_bad_db
    $error("edge_debounce: DB_CYCLES must be >= 1");
  end

`ifdef EDGE_DETECT_DEBOUNCE_EN
  localparam int unsigned CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Any cycle agreeing with stable restarts the count, so short glitches never land.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_in == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync_in;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= 1'b0;
    end else begin
      stable <= sync_in;
    end
  end
`endif

endmodule

// File: rtl/edge_detect_bank.sv
// N-channel synchronize / debounce / edge-detect bank with selectable edge polarity.
// Debounce is enabled by defining EDGE_DETECT_DEBOUNCE_EN.
module edge_detect_bank
  import edge_detect_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] level_in,
  input  logic [1:0]   mode,
  output logic [N-1:0] level_out,
  output logic [N-1:0] pulse,
  output logic         any_pulse
);

  if (N < 1) begin : g_bad_n
    $error("edge_detect_bank: N must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("edge_detect_bank: SYNC_STAGES must be >= 2");
  end

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] sync_out;
  logic [N-1:0] stable;
  logic [N-1:0] prev;
  logic [N-1:0] rise_c;
  logic [N-1:0] fall_c;
  logic [N-1:0] hit_c;

  // Metastability chain: stage 0 samples the raw asynchronous levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '{default: '0};
    end else begin
      sync_q[0] <= level_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  for (genvar g = 0; g < int'(N); g++) begin : g_ch
    edge_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .sync_in (sync_out[g]),
      .stable  (stable[g])
    );
  end

  assign level_out = stable;

  always_comb begin
    rise_c = stable & ~prev;
    fall_c = ~stable & prev;
    hit_c  = '0;
    case (mode)
      MODE_RISE: hit_c = rise_c;
      MODE_FALL: hit_c = fall_c;
      MODE_BOTH: hit_c = rise_c | fall_c;
      default:   hit_c = '0;
    endcase
  end

  // prev lags stable by one cycle, so each accepted change is seen for exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev      <= '0;
      pulse     <= '0;
      any_pulse <= 1'b0;
    end else begin
      prev      <= stable;
      pulse     <= hit_c;
      any_pulse <= |hit_c;
    end
  end

endmodule

// File: tb/tb_edge_detect_bank.sv
// Self-checking bench for edge_detect_bank: directed scenarios plus random levels,
// compared each cycle against a delay-line / persistence-window reference model.
module tb_edge_detect_bank;

  localparam int unsigned N  = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned DB = 4;
`ifdef EDGE_DETECT_DEBOUNCE_EN
  localparam int LAT        = SS + DB;
  localparam int GLITCH_LVL = 0;
  localparam int GLITCH_PUL = 0;
`else
  localparam int LAT        = SS + 1;
  localparam int GLITCH_LVL = 3;
  localparam int GLITCH_PUL = 2;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] level_in = '0;
  logic [1:0]   mode = 2'b00;
  logic [N-1:0] level_out;
  logic [N-1:0] pulse;
  logic         any_pulse;

  edge_detect_bank #(
    .N           (N),
    .SYNC_STAGES (SS),
    .DB_CYCLES   (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .level_in  (level_in),
    .mode      (mode),
    .level_out (level_out),
    .pulse     (pulse),
    .any_pulse (any_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: samples seen at each edge, and the debounced view of them.
  logic [N-1:0] samp_q [$];
  logic [N-1:0] sync_hist [$];
  logic [N-1:0] m_stab, m_prev, m_pulse;

  int cyc, full_cnt, lvl_first0, pul_first0, lvl1_cnt, nz_cnt;
  int pcnt [N];

  task automatic model_reset();
    samp_q.delete();
    sync_hist.delete();
    for (int i = 0; i < int'(SS); i++) samp_q.push_front('0);
    for (int i = 0; i < int'(DB); i++) sync_hist.push_front('0);
    m_stab  = '0;
    m_prev  = '0;
    m_pulse = '0;
  endtask

  task automatic clear_stats();
    cyc = 0; full_cnt = 0; lvl_first0 = -1; pul_first0 = -1; lvl1_cnt = 0; nz_cnt = 0;
    for (int i = 0; i < int'(N); i++) pcnt[i] = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] seen, new_stab, new_pulse;
    logic flip, rise, fall;
    samp_q.push_front(level_in);
    seen = samp_q[SS];
    void'(samp_q.pop_back());
`ifdef EDGE_DETECT_DEBOUNCE_EN
    sync_hist.push_front(seen);
    void'(sync_hist.pop_back());
    for (int ch = 0; ch < int'(N); ch++) begin
      flip = 1'b1;
      for (int k = 0; k < int'(DB); k++)
        if (sync_hist[k][ch] == m_stab[ch]) flip = 1'b0;
      new_stab[ch] = flip ? ~m_stab[ch] : m_stab[ch];
    end
`else
    new_stab = seen;
`endif
    for (int ch = 0; ch < int'(N); ch++) begin
      rise = m_stab[ch] && !m_prev[ch];
      fall = !m_stab[ch] && m_prev[ch];
      new_pulse[ch] = (mode == 2'd0 && rise) || (mode == 2'd1 && fall) ||
                      (mode == 2'd2 && (rise || fall));
    end
    m_prev  = m_stab;
    m_stab  = new_stab;
    m_pulse = new_pulse;
  endtask

  // One clock: update model at the edge, compare shortly after, return at negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("level_out", 32'(level_out), 32'(m_stab));
    check("pulse", 32'(pulse), 32'(m_pulse));
    check("any_pulse", 32'(any_pulse), 32'(|m_pulse));
    if (level_out[0] && lvl_first0 < 0) lvl_first0 = cyc;
    if (pulse[0] && pul_first0 < 0) pul_first0 = cyc;
    for (int i = 0; i < int'(N); i++) if (pulse[i]) pcnt[i]++;
    if (pulse == '1) full_cnt++;
    if (level_out[1]) lvl1_cnt++;
    if (pulse != '0) nz_cnt++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset between edges; outputs must drop without waiting for clk.
  task automatic do_reset(input logic [N-1:0] lvl_after);
    #2;
    rst = 1'b0;
    #1;
    check("rst_level_out", 32'(level_out), 32'h0);
    check("rst_pulse", 32'(pulse), 32'h0);
    check("rst_any_pulse", 32'(any_pulse), 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    level_in = lvl_after;
    rst = 1'b1;
    clear_stats();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clear_stats();
    @(negedge clk);
    @(negedge clk);

    // Single channel rise: latency and a single pulse.
    mode = 2'b00;
    do_reset(4'b0001);
    run(LAT + 6);
    check("lat_level0", 32'(lvl_first0), 32'(LAT));
    check("lat_pulse0", 32'(pul_first0), 32'(LAT + 1));
    check("pulse0_count", 32'(pcnt[0]), 32'd1);

    // Three-cycle glitch on channel 1.
    do_reset(4'b0010);
    run(3);
    level_in = 4'b0000;
    run(12);
    check("glitch_level1", 32'(lvl1_cnt), 32'(GLITCH_LVL));

    // Both edges, then falling only, on channel 2.
    for (int pass = 0; pass < 2; pass++) begin
      mode = (pass == 0) ? 2'b10 : 2'b01;
      do_reset(4'b0000);
      run(2);
      level_in = 4'b0100;
      run(20);
      level_in = 4'b0000;
      run(14);
      check(pass == 0 ? "both_pulse2" : "fall_pulse2", 32'(pcnt[2]), pass == 0 ? 32'd2 : 32'd1);
    end

    // All high at reset release: rising mode then disabled mode.
    mode = 2'b00;
    do_reset(4'b1111);
    run(LAT + 6);
    check("all_rise_cycles", 32'(full_cnt), 32'd1);
    check("all_rise_pulses", 32'(nz_cnt), 32'd1);
    mode = 2'b11;
    do_reset(4'b1111);
    run(LAT + 6);
    check("off_no_pulse", 32'(nz_cnt), 32'd0);
    check("off_level", 32'(level_out), 32'hF);

    // Reset during a debounce on channel 3 discards the change.
    mode = 2'b10;
    do_reset(4'b1000);
    run(SS + 2);
    do_reset(4'b0000);
    run(LAT + 6);
    check("abort_pulse3", 32'(pcnt[3]), 32'd0);

    // One-cycle glitch on channel 0 with both edges selected.
    mode = 2'b10;
    do_reset(4'b0000);
    run(2);
    level_in = 4'b0001;
    run(1);
    level_in = 4'b0000;
    run(LAT + 6);
    check("glitch1_pulse0", 32'(pcnt[0]), 32'(GLITCH_PUL));

    // Random slowly-toggling levels with occasional mode changes and resets.
    for (int blk = 0; blk < 4; blk++) begin
      mode = 2'($urandom_range(0, 3));
      do_reset(N'($urandom_range(0, 15)));
      for (int c = 0; c < 150; c++) begin
        for (int i = 0; i < int'(N); i++)
          if ($urandom_range(0, 7) == 0) level_in[i] = ~level_in[i];
        if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 99) == 0) do_reset(level_in);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
